ysyx_25040105_mem_arbiter: RTL and testbench

YSYX_25040105_MEM_ARBITER -- requirements
Module: ysyx_25040105_mem_arbiter

---
 rtl/ysyx_25040105_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ysyx_25040105_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040105_mem_arbiter.sv
// Purpose: arbitrates IFU and LSU requests onto one shared memory port; one transaction in flight at a time.
// Latency: accept -> mem_req_valid next cycle; response pulse one cycle after mem_resp_valid, or err after MAX_WAIT response cycles.
// Backpressure: req_ready only in IDLE for the winner; request fields held stable while mem_req_ready is low.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-low reset
//   ifu_req_* / ifu_r*       IFU read request and response (rvalid single-cycle pulse, rdata/err held)
//   lsu_req_* / lsu_r*       LSU read/write request and response (write acks use lsu_rvalid)
//   mem_req_* / mem_resp_*   shared memory port
//   busy                     high whenever the arbiter is not IDLE
// Build option: define ARB_RR_EN for round-robin arbitration; default is fixed priority, LSU over IFU.
module ysyx_25040105_mem_arbiter #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Last cycle in which the counter may still be waiting; reaching it without a response times out.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]  state;
    logic        owner;
    logic [7:0]  wait_cnt;

    logic        grant_lsu;
    logic        accept_ifu;
    logic        accept_lsu;
    logic        timeout;
    logic        resp_fire;
    logic [31:0] resp_data;
    logic        resp_err;

`ifdef ARB_RR_EN
    logic        last;

    // On a tie the requester that did not win the previous accept goes first.
    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || (last == OWN_IFU));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= OWN_IFU;
        end else if (accept_lsu) begin
            last <= OWN_LSU;
        end else if (accept_ifu) begin
            last <= OWN_IFU;
        end
    end
`else
    always_comb begin
        grant_lsu = lsu_req_valid;
    end
`endif

    assign lsu_req_ready = (state == S_IDLE) && grant_lsu;
    assign ifu_req_ready = (state == S_IDLE) && ifu_req_valid && !grant_lsu;
    assign accept_lsu    = lsu_req_valid && lsu_req_ready;
    assign accept_ifu    = ifu_req_valid && ifu_req_ready;

    // Derived from state so an asynchronous reset drops the request immediately.
    assign mem_req_valid = (state == S_REQ);
    assign busy          = (state != S_IDLE);

    assign timeout   = (state == S_RESP) && !mem_resp_valid && (wait_cnt == WAIT_LAST);
    assign resp_fire = (state == S_RESP) && (mem_resp_valid || timeout);
    assign resp_data = mem_resp_valid ? mem_rdata : 32'h0;
    assign resp_err  = !mem_resp_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner     <= OWN_IFU;
            wait_cnt  <= 8'h0;
            mem_addr  <= 32'h0;
            mem_wen   <= 1'b0;
            mem_wdata <= 32'h0;
            mem_wmask <= 4'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_lsu) begin
                        mem_addr  <= lsu_addr;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                        owner     <= OWN_LSU;
                        state     <= S_REQ;
                    end else if (accept_ifu) begin
                        mem_addr  <= ifu_addr;
                        mem_wen   <= 1'b0;
                        mem_wdata <= 32'h0;
                        mem_wmask <= 4'h0;
                        owner     <= OWN_IFU;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        wait_cnt <= 8'h0;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_fire) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Response registers: rvalid is a one-cycle pulse, data/err hold until the next pulse for that requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= 32'h0;
            ifu_err    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= 32'h0;
            lsu_err    <= 1'b0;
        end else begin
            ifu_rvalid <= resp_fire && (owner == OWN_IFU);
            lsu_rvalid <= resp_fire && (owner == OWN_LSU);
            if (resp_fire && (owner == OWN_IFU)) begin
                ifu_rdata <= resp_data;
                ifu_err   <= resp_err;
            end
            if (resp_fire && (owner == OWN_LSU)) begin
                lsu_rdata <= resp_data;
                lsu_err   <= resp_err;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040105_mem_arbiter.sv
// Purpose: self-checking bench for ysyx_25040105_mem_arbiter with a transaction-level reference model.
// Timing: inputs driven 1ns after the rising edge, outputs sampled 4ns later (before the falling edge).
// The bench plays the memory: it controls mem_req_ready stalls and mem_resp_valid delay per transaction.
module tb_ysyx_25040105_mem_arbiter;

    localparam int MAX_W = 4;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rvalid, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rvalid, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    ysyx_25040105_mem_arbiter #(.MAX_WAIT(MAX_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: tie-break pointer and the held response values per requester (0=IFU, 1=LSU).
    logic        last_lsu;
    logic [31:0] exp_rd [2];
    logic        exp_er [2];

    typedef struct packed {
        logic        irdy;
        logic        lrdy;
        logic [31:0] maddr;
        logic        mwen;
        logic [31:0] mwdata;
        logic [3:0]  mwmask;
        logic        req_ok;
        logic        irv;
        logic        lrv;
        logic [31:0] irdata;
        logic [31:0] lrdata;
        logic        ierr;
        logic        lerr;
        logic        busy_p;
    } obs_t;

    // Winner of an arbitration round: 1 means LSU.
    function automatic logic winner(input logic iv, input logic lv);
        logic tie_lsu;
`ifdef ARB_RR_EN
        tie_lsu = !last_lsu;
`else
        tie_lsu = 1'b1;
`endif
        return (iv && lv) ? tie_lsu : lv;
    endfunction

    task automatic model_reset();
        last_lsu  = 1'b0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        exp_er[0] = 1'b0;  exp_er[1] = 1'b0;
    endtask

    // Records one completed transaction in the model: who won, and what the memory did.
    task automatic model_txn(input logic w, input int delay, input logic [31:0] rd);
        last_lsu = w;
        exp_er[w] = (delay >= MAX_W);
        exp_rd[w] = (delay >= MAX_W) ? 32'h0 : rd;
    endtask

    // Drives one full transaction; returns what was observed. Called during an IDLE cycle,
    // returns at the sample point of the response-pulse cycle.
    task automatic run_txn(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la,
                           input logic lw, input logic [31:0] lwd, input logic [3:0] lwm,
                           input int stall, input int delay, input logic [31:0] rd, output obs_t o);
        int nresp;
        o = '0;
        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        o.irdy = ifu_req_ready;
        o.lrdy = lsu_req_ready;
        @(posedge clk); #1;
        ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom); lsu_wen = 1'($urandom);
        o.req_ok = 1'b1;
        for (int s = 0; s <= stall; s++) begin
            mem_req_ready  = (s == stall);
            ifu_req_valid  = (s < stall);
            lsu_req_valid  = (s < stall);
            mem_resp_valid = 1'($urandom);
            mem_rdata      = $urandom;
            #4;
            if (s == 0) begin
                o.maddr = mem_addr; o.mwen = mem_wen; o.mwdata = mem_wdata; o.mwmask = mem_wmask;
            end
            if (!mem_req_valid || !busy || ifu_req_ready || lsu_req_ready ||
                mem_addr !== o.maddr || mem_wen !== o.mwen || mem_wdata !== o.mwdata || mem_wmask !== o.mwmask)
                o.req_ok = 1'b0;
            @(posedge clk); #1;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
        nresp = (delay < MAX_W) ? delay + 1 : MAX_W;
        for (int c = 0; c < nresp; c++) begin
            mem_resp_valid = (c == delay);
            mem_rdata      = (c == delay) ? rd : $urandom;
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b0;
        #4;
        o.irv = ifu_rvalid; o.lrv = lsu_rvalid;
        o.irdata = ifu_rdata; o.lrdata = lsu_rdata;
        o.ierr = ifu_err; o.lerr = lsu_err;
        o.busy_p = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_addr = 0;
        lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        model_reset();
        #22;
        n_cmp++;
        if ({busy, mem_req_valid, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got busy/mrv/irv/lrv/ierr/lerr=%b want 000000",
                     {busy, mem_req_valid, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err});
        end
        n_cmp++;
        if ({ifu_rdata, lsu_rdata, mem_addr, mem_wdata} !== 128'h0 || {mem_wen, mem_wmask} !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_data got ird=%h lrd=%h addr=%h wd=%h wen=%b wm=%h want all 0",
                     ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wen, mem_wmask);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #4;
        n_cmp++;
        if ({busy, ifu_req_ready, lsu_req_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy/irdy/lrdy=%b want 000", {busy, ifu_req_ready, lsu_req_ready});
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic w;
        for (int r = 0; r < 2; r++) begin
            w = winner(1'b1, 1'b1);
            run_txn(1'b1, 32'h8000_0200 + 32'(r), 1'b1, 32'h8000_0300 + 32'(r), 1'b0, 32'h0, 4'h0,
                    0, 0, 32'h1234_0000 + 32'(r), o);
            model_txn(w, 0, 32'h1234_0000 + 32'(r));
            n_cmp++;
            if ({o.irdy, o.lrdy} !== {!w, w}) begin
                n_fail++;
                $display("FAIL b2b_grant round=%0d got irdy/lrdy=%b%b want %b%b", r, o.irdy, o.lrdy, !w, w);
            end
            n_cmp++;
            if (o.maddr !== (w ? 32'h8000_0300 + 32'(r) : 32'h8000_0200 + 32'(r))) begin
                n_fail++;
                $display("FAIL b2b_addr round=%0d got %h", r, o.maddr);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ifu_read();
        obs_t o;
        run_txn(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0010_0073, o);
        model_txn(1'b0, 0, 32'h0010_0073);
        n_cmp++;
        if (o.maddr !== 32'h8000_0000 || o.mwen !== 1'b0 || !o.irdy) begin
            n_fail++;
            $display("FAIL ifu_req got addr=%h wen=%b irdy=%b want 80000000 0 1", o.maddr, o.mwen, o.irdy);
        end
        n_cmp++;
        if ({o.irv, o.lrv} !== 2'b10 || o.irdata !== 32'h0010_0073 || o.ierr !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_resp got rv=%b%b rdata=%h err=%b want 10 00100073 0", o.irv, o.lrv, o.irdata, o.ierr);
        end
        @(posedge clk); #4;
        n_cmp++;
        if (ifu_rvalid !== 1'b0 || ifu_rdata !== 32'h0010_0073) begin
            n_fail++;
            $display("FAIL ifu_pulse_width got rvalid=%b rdata=%h want 0 00100073", ifu_rvalid, ifu_rdata);
        end
    endtask

    task automatic test_lsu_write();
        obs_t o;
        run_txn(1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, 1, 32'h5555_AAAA, o);
        model_txn(1'b1, 1, 32'h5555_AAAA);
        n_cmp++;
        if (o.maddr !== 32'h8000_0100 || o.mwen !== 1'b1 || o.mwdata !== 32'hDEAD_BEEF || o.mwmask !== 4'b0011) begin
            n_fail++;
            $display("FAIL lsu_wr_req got addr=%h wen=%b wd=%h wm=%b", o.maddr, o.mwen, o.mwdata, o.mwmask);
        end
        n_cmp++;
        if ({o.irv, o.lrv} !== 2'b01 || o.lerr !== 1'b0) begin
            n_fail++;
            $display("FAIL lsu_wr_ack got irv/lrv=%b%b err=%b want 01 0", o.irv, o.lrv, o.lerr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        obs_t o;
        run_txn(1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 5, 2, 32'hCAFE_F00D, o);
        model_txn(1'b0, 2, 32'hCAFE_F00D);
        n_cmp++;
        if (o.req_ok !== 1'b1 || o.maddr !== 32'h8000_0040) begin
            n_fail++;
            $display("FAIL stall_hold got stable=%b addr=%h want 1 80000040", o.req_ok, o.maddr);
        end
        n_cmp++;
        if (o.irv !== 1'b1 || o.irdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL stall_resp got rv=%b rdata=%h want 1 cafef00d", o.irv, o.irdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(1'b0, 32'h0, 1'b1, 32'h9000_0000, 1'b0, 32'h0, 4'h0, 0, 10, 32'hFFFF_FFFF, o);
        model_txn(1'b1, 10, 32'hFFFF_FFFF);
        n_cmp++;
        if (o.lrv !== 1'b1 || o.lerr !== 1'b1 || o.lrdata !== 32'h0 || o.busy_p !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_resp got rv=%b err=%b rdata=%h busy=%b want 1 1 0 0", o.lrv, o.lerr, o.lrdata, o.busy_p);
        end
        run_txn(1'b1, 32'h8000_0080, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 0, 3, 32'h0BAD_C0DE, o);
        model_txn(1'b0, 3, 32'h0BAD_C0DE);
        n_cmp++;
        if (o.irdy !== 1'b1 || o.irv !== 1'b1 || o.ierr !== 1'b0 || o.irdata !== 32'h0BAD_C0DE || o.lerr !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_next got irdy=%b rv=%b err=%b rdata=%h lerr=%b", o.irdy, o.irv, o.ierr, o.irdata, o.lerr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drop();
        ifu_req_valid = 1'b1; ifu_addr = 32'h1;
        #3;
        ifu_req_valid = 1'b0;
        @(posedge clk); #4;
        n_cmp++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_valid got busy=%b mrv=%b want 0 0", busy, mem_req_valid);
        end
        #2;
    endtask

    task automatic test_random();
        obs_t o;
        logic iv, lv, lw, w;
        logic [31:0] ia, la, lwd, rd;
        logic [3:0] lwm;
        logic [31:0] exp_addr;
        int sel, stall, delay;
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(1, 3);
            iv = sel[0]; lv = sel[1];
            ia = $urandom; la = $urandom; lwd = $urandom; rd = $urandom;
            lw = 1'($urandom); lwm = 4'($urandom);
            stall = $urandom_range(0, 3);
            delay = $urandom_range(0, 6);
            w = winner(iv, lv);
            run_txn(iv, ia, lv, la, lw, lwd, lwm, stall, delay, rd, o);
            model_txn(w, delay, rd);
            exp_addr = w ? la : ia;
            n_cmp++;
            if ({o.irdy, o.lrdy} !== {!w, w}) begin
                n_fail++;
                $display("FAIL rnd_grant t=%0d iv=%b lv=%b got %b%b want %b%b", t, iv, lv, o.irdy, o.lrdy, !w, w);
            end
            n_cmp++;
            if (o.maddr !== exp_addr || o.mwen !== (w & lw) || o.mwmask !== (w ? lwm : 4'h0) ||
                (w && o.mwdata !== lwd) || o.req_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_req t=%0d got addr=%h wen=%b wm=%h wd=%h ok=%b want addr=%h", t,
                         o.maddr, o.mwen, o.mwmask, o.mwdata, o.req_ok, exp_addr);
            end
            n_cmp++;
            if ({o.irv, o.lrv} !== {!w, w} || o.busy_p !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_pulse t=%0d got rv=%b%b busy=%b want %b%b 0", t, o.irv, o.lrv, o.busy_p, !w, w);
            end
            n_cmp++;
            if (o.irdata !== exp_rd[0] || o.lrdata !== exp_rd[1] || o.ierr !== exp_er[0] || o.lerr !== exp_er[1]) begin
                n_fail++;
                $display("FAIL rnd_data t=%0d got ird=%h ie=%b lrd=%h le=%b want ird=%h ie=%b lrd=%h le=%b", t,
                         o.irdata, o.ierr, o.lrdata, o.lerr, exp_rd[0], exp_er[0], exp_rd[1], exp_er[1]);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #4;
                n_cmp++;
                if ({ifu_rvalid, lsu_rvalid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rnd_single_pulse t=%0d got rv=%b%b want 00", t, ifu_rvalid, lsu_rvalid);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midtxn();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0400;
        lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_pre got busy=%b want 1", busy);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rst_async got busy=%b mrv=%b ird=%h lrd=%h want 0 0 0 0", busy, mem_req_valid, ifu_rdata, lsu_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #4;
            n_cmp++;
            if ({ifu_rvalid, lsu_rvalid, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_rst_after c=%0d got irv/lrv/busy=%b want 000", c, {ifu_rvalid, lsu_rvalid, busy});
            end
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ifu_read();
        test_lsu_write();
        test_stall();
        test_timeout();
        test_drop();
        test_random();
        test_reset_midtxn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
